// File: rtl/instr_encoder_loader.sv
// Instruction encoder / boot-loader: packs DP, LDR/STR and B field bundles into
// 32-bit words and writes them sequentially into imem while holding the CPU in reset.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_op,
    input  logic              in_i,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_l,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_op,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic        accept;
    logic        is_illegal;
    logic        is_full;
    logic        last_q;
    logic [31:0] enc_word;

    assign accept     = in_valid & in_ready;
    assign is_illegal = (in_op == 2'b11);
    assign is_full    = (word_count == MAX_CNT);

    always_comb begin
        enc_word = '0;
        case (in_op)
            2'b00:   enc_word = {in_cond, 2'b00, in_i, in_cmd, in_s, in_rn, in_rd, in_src2};
            2'b01:   enc_word = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_l,
                                 in_rn, in_rd, in_src2};
            2'b10:   enc_word = {in_cond, 2'b10, 2'b10, in_imm24};
            default: enc_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (is_full)         state_nx = S_DONE;
                    else if (is_illegal) state_nx = in_last ? S_DONE : S_LOAD;
                    else                 state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we   = 1'b1;
                state_nx = last_q ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = S_LOAD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address/count advance on leaving WRITE so the strobe cycle sees the current slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            word_count <= '0;
            err_op     <= 1'b0;
            err_ovf    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mem_addr   <= BASE;
                        word_count <= '0;
                        err_op     <= 1'b0;
                        err_ovf    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (is_full) begin
                            err_ovf <= 1'b1;
                        end else if (is_illegal) begin
                            err_op <= 1'b1;
                        end else begin
                            mem_wdata <= enc_word;
                            last_q    <= in_last;
                        end
                    end
                end
                S_WRITE: begin
                    mem_addr   <= mem_addr + ADDR_W'(1);
                    word_count <= word_count + (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: spec vectors, multi-cycle corner
// sequences and randomized sessions against an arithmetic encoding model.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [1:0]  in_op;
    logic        in_i, in_s, in_l;
    logic [3:0]  in_cmd, in_cond, in_rn, in_rd;
    logic [11:0] in_src2;
    logic [23:0] in_imm24;

    logic        a_in_ready, a_mem_we, a_cpu_hold, a_done, a_err_op, a_err_ovf;
    logic [5:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [6:0]  a_word_count;

    logic        b_in_ready, b_mem_we, b_cpu_hold, b_done, b_err_op, b_err_ovf;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_word_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_last(in_last), .in_op(in_op), .in_i(in_i), .in_cmd(in_cmd), .in_s(in_s),
        .in_l(in_l), .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
        .in_imm24(in_imm24), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .word_count(a_word_count), .cpu_hold(a_cpu_hold), .done(a_done), .err_op(a_err_op),
        .err_ovf(a_err_ovf)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2), .MAX_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_last(in_last), .in_op(in_op), .in_i(in_i), .in_cmd(in_cmd), .in_s(in_s),
        .in_l(in_l), .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
        .in_imm24(in_imm24), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .word_count(b_word_count), .cpu_hold(b_cpu_hold), .done(b_done), .err_op(b_err_op),
        .err_ovf(b_err_ovf)
    );

    typedef struct {
        logic [1:0]  op;
        logic        i;
        logic [3:0]  cmd;
        logic        s;
        logic        l;
        logic [3:0]  cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t wa[$], wb[$], ea[$], eb[$];

    always @(negedge clk) begin
        if (a_mem_we) wa.push_back('{addr: 32'(a_mem_addr), data: a_mem_wdata});
        if (b_mem_we) wb.push_back('{addr: 32'(b_mem_addr), data: b_mem_wdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(logic [1:0] op, logic i, logic [3:0] cmd, logic s, logic l,
                                   logic [3:0] cond, logic [3:0] rn, logic [3:0] rd,
                                   logic [11:0] src2, logic [23:0] imm24);
        bundle_t b;
        b.op = op; b.i = i; b.cmd = cmd; b.s = s; b.l = l; b.cond = cond;
        b.rn = rn; b.rd = rd; b.src2 = src2; b.imm24 = imm24;
        return b;
    endfunction

    // Reference word built by positional weights rather than concatenation.
    function automatic logic [31:0] ref_enc(bundle_t b);
        logic [31:0] funct;
        if (b.op == 2'd2)
            return 32'(b.cond) * 32'h1000_0000 + 32'h0A00_0000 + 32'(b.imm24);
        if (b.op == 2'd0) funct = 32'(b.i) * 32 + 32'(b.cmd) * 2 + 32'(b.s);
        else              funct = 24 + 32'(b.l);
        return 32'(b.cond) * 32'h1000_0000 + 32'(b.op) * 32'h0400_0000 + funct * 32'h10_0000
             + 32'(b.rn) * 32'h1_0000 + 32'(b.rd) * 32'h1000 + 32'(b.src2);
    endfunction

    function automatic bundle_t rnd_bundle(bit allow_illegal);
        bundle_t b;
        if (allow_illegal && $urandom_range(0, 7) == 0) b.op = 2'd3;
        else b.op = 2'($urandom_range(0, 2));
        b.i = 1'($urandom); b.cmd = 4'($urandom); b.s = 1'($urandom); b.l = 1'($urandom);
        b.cond = 4'($urandom); b.rn = 4'($urandom); b.rd = 4'($urandom);
        b.src2 = 12'($urandom); b.imm24 = 24'($urandom);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bundle_t b);
        in_op = b.op; in_i = b.i; in_cmd = b.cmd; in_s = b.s; in_l = b.l; in_cond = b.cond;
        in_rn = b.rn; in_rd = b.rd; in_src2 = b.src2; in_imm24 = b.imm24;
    endtask

    task automatic start_session();
        wa.delete(); wb.delete(); ea.delete(); eb.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(bundle_t b, logic last, int gap);
        int n;
        repeat (gap) tick();
        drive(b);
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!a_in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready_seen", a_in_ready, 1);
        if (a_in_ready) tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!a_done && n < 20) begin
            tick();
            n++;
        end
        chk("done_reached", a_done, 1);
    endtask

    task automatic cmp_writes(string nm);
        chk($sformatf("%s_a_nwrites", nm), wa.size(), ea.size());
        for (int k = 0; k < ea.size() && k < wa.size(); k++) begin
            chk($sformatf("%s_a_addr%0d", nm, k), wa[k].addr, ea[k].addr);
            chk($sformatf("%s_a_data%0d", nm, k), wa[k].data, ea[k].data);
        end
    endtask

    task automatic cmp_writes_b(string nm);
        chk($sformatf("%s_b_nwrites", nm), wb.size(), eb.size());
        for (int k = 0; k < eb.size() && k < wb.size(); k++) begin
            chk($sformatf("%s_b_addr%0d", nm, k), wb[k].addr, eb[k].addr);
            chk($sformatf("%s_b_data%0d", nm, k), wb[k].data, eb[k].data);
        end
    endtask

    vec_t    vecs[7];
    bundle_t ob[5];

    initial begin
        vecs[0] = '{mk(2'd0, 1'b1, 4'h4, 1'b0, 1'b0, 4'hE, 4'h2, 4'h1, 12'h005, 24'hABCDEF), 32'hE2821005};
        vecs[1] = '{mk(2'd1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hE, 4'h0, 4'h3, 12'h008, 24'h000000), 32'hE5903008};
        vecs[2] = '{mk(2'd1, 1'b1, 4'hF, 1'b1, 1'b0, 4'hE, 4'h0, 4'h3, 12'h008, 24'h123456), 32'hE5803008};
        vecs[3] = '{mk(2'd2, 1'b1, 4'hF, 1'b1, 1'b1, 4'h0, 4'hF, 4'hF, 12'hFFF, 24'h000002), 32'h0A000002};
        vecs[4] = '{mk(2'd0, 1'b0, 4'h2, 1'b1, 1'b0, 4'hE, 4'h4, 4'h4, 12'h005, 24'h000000), 32'hE0544005};
        vecs[5] = '{mk(2'd0, 1'b1, 4'hD, 1'b0, 1'b1, 4'hE, 4'h0, 4'h7, 12'h0FF, 24'h000000), 32'hE3A070FF};
        vecs[6] = '{mk(2'd2, 1'b0, 4'h0, 1'b0, 1'b0, 4'hE, 4'h0, 4'h0, 12'h000, 24'hFFFFFE), 32'hEAFFFFFE};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        drive(mk(2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 12'h0, 24'h0));
        #12;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_mem_we", a_mem_we, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_mem_wdata", a_mem_wdata, 0);
        chk("rst_word_count", a_word_count, 0);
        chk("rst_cpu_hold", a_cpu_hold, 1);
        chk("rst_done", a_done, 0);
        chk("rst_err_op", a_err_op, 0);
        chk("rst_err_ovf", a_err_ovf, 0);
        chk("rst_b_mem_addr", b_mem_addr, 2);
        reset = 1'b0;
        tick();

        // Bundles offered while idle are ignored.
        drive(vecs[0].b);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("idle_no_write", wa.size(), 0);
        chk("idle_in_ready", a_in_ready, 0);
        chk("idle_cpu_hold", a_cpu_hold, 1);

        // Table vectors as one program.
        start_session();
        chk("load_in_ready", a_in_ready, 1);
        for (int k = 0; k < 7; k++) begin
            send(vecs[k].b, (k == 6), k % 2);
            ea.push_back('{addr: 32'(k), data: vecs[k].exp});
        end
        wait_done();
        chk("tbl_word_count", a_word_count, 7);
        chk("tbl_cpu_hold", a_cpu_hold, 0);
        chk("tbl_err_op", a_err_op, 0);
        chk("tbl_err_ovf", a_err_ovf, 0);
        cmp_writes("tbl");

        // Illegal op between two legal words; start mid-session must be ignored.
        start_session();
        send(vecs[0].b, 1'b0, 0);
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(mk(2'd3, 1'b1, 4'h1, 1'b1, 1'b1, 4'hE, 4'h1, 4'h1, 12'h111, 24'h111111), 1'b0, 0);
        chk("ill_err_op", a_err_op, 1);
        send(vecs[4].b, 1'b1, 1);
        wait_done();
        ea.push_back('{addr: 0, data: 32'hE2821005});
        ea.push_back('{addr: 1, data: 32'hE0544005});
        chk("ill_word_count", a_word_count, 2);
        chk("ill_err_op_sticky", a_err_op, 1);
        chk("ill_err_ovf", a_err_ovf, 0);
        cmp_writes("ill");

        // Restart clears session state; dut4 (4 words, base 2) overflows on the fifth bundle.
        start_session();
        chk("restart_err_op", a_err_op, 0);
        chk("restart_word_count", a_word_count, 0);
        chk("restart_mem_addr", a_mem_addr, 0);
        chk("restart_done", a_done, 0);
        chk("restart_cpu_hold", a_cpu_hold, 1);
        for (int k = 0; k < 5; k++) begin
            ob[k] = rnd_bundle(1'b0);
            ea.push_back('{addr: 32'(k), data: ref_enc(ob[k])});
            if (k < 4) eb.push_back('{addr: 32'((k + 2) % 4), data: ref_enc(ob[k])});
            send(ob[k], (k == 4), 0);
        end
        wait_done();
        chk("ovf_b_err_ovf", b_err_ovf, 1);
        chk("ovf_b_done", b_done, 1);
        chk("ovf_b_cpu_hold", b_cpu_hold, 0);
        chk("ovf_b_word_count", b_word_count, 4);
        chk("ovf_b_err_op", b_err_op, 0);
        chk("ovf_b_in_ready", b_in_ready, 0);
        chk("ovf_a_err_ovf", a_err_ovf, 0);
        chk("ovf_a_word_count", a_word_count, 5);
        cmp_writes("ovf");
        cmp_writes_b("ovf");

        // Reset asserted during the write strobe aborts immediately.
        start_session();
        drive(vecs[0].b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rw_in_write", a_mem_we, 1);
        #1 reset = 1'b1;
        #1;
        chk("rw_mem_we", a_mem_we, 0);
        chk("rw_cpu_hold", a_cpu_hold, 1);
        chk("rw_mem_addr", a_mem_addr, 0);
        chk("rw_done", a_done, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_idle_in_ready", a_in_ready, 0);
        chk("rw_no_write", wa.size(), 0);
        start_session();
        send(vecs[4].b, 1'b1, 0);
        wait_done();
        ea.push_back('{addr: 0, data: 32'hE0544005});
        chk("rw_word_count", a_word_count, 1);
        cmp_writes("rw");

        // Randomized sessions against the reference model.
        for (int s = 0; s < 8; s++) begin
            int unsigned n, cnt;
            logic        eop;
            bundle_t     b;
            start_session();
            n = $urandom_range(1, 10);
            cnt = 0;
            eop = 1'b0;
            for (int unsigned k = 0; k < n; k++) begin
                b = rnd_bundle(1'b1);
                if (b.op == 2'd3) eop = 1'b1;
                else begin
                    ea.push_back('{addr: cnt, data: ref_enc(b)});
                    cnt++;
                end
                send(b, (k == n - 1), int'($urandom_range(0, 3)));
            end
            wait_done();
            chk($sformatf("rnd%0d_word_count", s), a_word_count, cnt);
            chk($sformatf("rnd%0d_err_op", s), a_err_op, eop);
            chk($sformatf("rnd%0d_cpu_hold", s), a_cpu_hold, 0);
            cmp_writes($sformatf("rnd%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
